pdp8_trace_buf: RTL and testbench

- Synthesizable on-chip instruction trace buffer for the pdp8 core.
- Samples pc/ir(mb)/l/ac/ion once per fetch into a parametrised RAM.
- Supports fill, circular and PC-trigger capture modes, and stops automatically on CPU halt.
- Captured entries are drained oldest-first over a valid/ready port, for a UART dumper or a bench.

---
 rtl/pdp8_trace_buf.sv | 189 ++++++++++++++++++
 tb/tb_pdp8_trace_buf.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pdp8_trace_buf.sv
// Instruction trace buffer for the pdp8 core: one entry per fetch, drained oldest-first.
// Optional cycle timestamps per entry are built when PDP8_TRACE_TIMESTAMP_EN is defined.
module pdp8_trace_buf #(
  parameter int          ADDR_W      = 8,
  parameter int          POST_CNT    = 16,
  parameter logic [3:0]  FETCH_STATE = 4'b0000,
  parameter logic [3:0]  HALT_STATE  = 4'b1100,
  parameter int          CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [11:0]       trig_pc,
  input  logic [3:0]        cpu_state,
  input  logic [11:0]       cpu_pc,
  input  logic [11:0]       cpu_mb,
  input  logic              cpu_l,
  input  logic [11:0]       cpu_ac,
  input  logic              cpu_ion,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [37:0]       rd_data,
  output logic [CNT_W-1:0]  rd_ts,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              wrapped,
  output logic              triggered
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ARMED = 2'b01;
  localparam logic [1:0] S_POST  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [ADDR_W:0]   FULL    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W-1:0] POST_LD = POST_CNT[ADDR_W-1:0];

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic              halted_q, halted_d;
  logic              wrapped_q, wrapped_d;
  logic              triggered_q, triggered_d;
  logic              prev_fetch_q;
  logic              capture;
  logic              fill_mode;
  logic              wr_en;

  logic [37:0] mem [DEPTH];

  // One capture per fetch: rising edge of "cpu_state is the fetch code".
  assign capture   = (cpu_state == FETCH_STATE) && !prev_fetch_q;
  assign fill_mode = (mode_q == 2'b00) || (mode_q == 2'b11);
  assign rd_valid  = (state_q == S_DONE) && (count_q != '0);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    post_d      = post_q;
    halted_d    = halted_q;
    wrapped_d   = wrapped_q;
    triggered_d = triggered_q;
    wr_en       = 1'b0;
    if (arm) begin
      state_d     = S_ARMED;
      mode_d      = mode;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      post_d      = '0;
      halted_d    = 1'b0;
      wrapped_d   = 1'b0;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        S_ARMED, S_POST: begin
          if (cpu_state == HALT_STATE) begin
            halted_d = 1'b1;
            state_d  = S_DONE;
          end else if (stop) begin
            state_d = S_DONE;
          end else if (capture) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            // Only overwriting modes can arrive here with a full buffer.
            if (count_q == FULL) begin
              rd_ptr_d  = rd_ptr_q + PTR_ONE;
              wrapped_d = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
            if (state_q == S_POST) begin
              post_d = post_q - PTR_ONE;
              if (post_q == PTR_ONE) state_d = S_DONE;
            end else if (fill_mode) begin
              if (count_q == FULL - CNT_ONE) state_d = S_DONE;
            end else if (mode_q == 2'b10 && cpu_pc == trig_pc) begin
              triggered_d = 1'b1;
              post_d      = POST_LD;
              state_d     = (POST_LD == '0) ? S_DONE : S_POST;
            end
          end
        end
        S_DONE: begin
          if (rd_valid && rd_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'b00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      post_q       <= '0;
      halted_q     <= 1'b0;
      wrapped_q    <= 1'b0;
      triggered_q  <= 1'b0;
      prev_fetch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      post_q       <= post_d;
      halted_q     <= halted_d;
      wrapped_q    <= wrapped_d;
      triggered_q  <= triggered_d;
      prev_fetch_q <= (cpu_state == FETCH_STATE);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {cpu_pc, cpu_mb, cpu_l, cpu_ac, cpu_ion};
  end

  assign rd_data = rd_valid ? mem[rd_ptr_q] : '0;

`ifdef PDP8_TRACE_TIMESTAMP_EN
  localparam logic [CNT_W-1:0] TS_ONE = 1;
  logic [CNT_W-1:0] ts_q, ts_d;
  logic [CNT_W-1:0] ts_mem [DEPTH];

  assign ts_d = arm ? '0 : ts_q + TS_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign rd_ts = rd_valid ? ts_mem[rd_ptr_q] : '0;
`else
  assign rd_ts = '0;
`endif

  assign count     = count_q;
  assign busy      = (state_q == S_ARMED) || (state_q == S_POST);
  assign done      = (state_q == S_DONE);
  assign halted    = halted_q;
  assign wrapped   = wrapped_q;
  assign triggered = triggered_q;

endmodule

// File: tb/tb_pdp8_trace_buf.sv
// Directed bench for pdp8_trace_buf with an 8-entry buffer and a 2-fetch post window.
module tb_pdp8_trace_buf;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              arm = 1'b0, stop = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [11:0]       trig_pc = '0;
  logic [3:0]        cpu_state = 4'b0001;
  logic [11:0]       cpu_pc = '0, cpu_mb = '0, cpu_ac = '0;
  logic              cpu_l = 1'b0, cpu_ion = 1'b0;
  logic              rd_valid, rd_ready = 1'b0;
  logic [37:0]       rd_data;
  logic [CNT_W-1:0]  rd_ts;
  logic [ADDR_W:0]   count;
  logic              busy, done, halted, wrapped, triggered;

  int errors = 0;
  int checks = 0;

  pdp8_trace_buf #(.ADDR_W(ADDR_W), .POST_CNT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .stop(stop), .mode(mode),
    .trig_pc(trig_pc), .cpu_state(cpu_state), .cpu_pc(cpu_pc), .cpu_mb(cpu_mb),
    .cpu_l(cpu_l), .cpu_ac(cpu_ac), .cpu_ion(cpu_ion), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_ts(rd_ts), .count(count),
    .busy(busy), .done(done), .halted(halted), .wrapped(wrapped), .triggered(triggered)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] m);
    arm = 1'b1; mode = m;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // One fetch cycle followed by (gap) non-fetch cycles.
  task automatic fetch(input logic [11:0] pc, input int gap);
    cpu_state = 4'b0000; cpu_pc = pc; cpu_mb = pc ^ 12'o7777;
    tick();
    cpu_state = 4'b0001;
    for (int g = 0; g < gap; g++) tick();
  endtask

  task automatic drain(input string tag, input logic [11:0] first_pc, input int n);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 64'(rd_valid), 64'(1));
      check({tag, "_pc"}, 64'(rd_data[37:26]), 64'(first_pc + 12'(i)));
      tick();
    end
    rd_ready = 1'b0;
    check({tag, "_empty"}, 64'(rd_valid), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(rd_valid), 64'(0));
    check({tag, "_data"},  64'(rd_data), 64'(0));
    check({tag, "_ts"},    64'(rd_ts), 64'(0));
    check({tag, "_count"}, 64'(count), 64'(0));
    check({tag, "_flags"}, 64'({busy, done, halted, wrapped, triggered}), 64'(0));
  endtask

  logic [CNT_W-1:0] prev_ts;

  initial begin
    tick(); tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Fill mode: stops after the 8th fetch, keeps the first eight.
    do_arm(2'b00);
    check("fill_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 10; i++) begin
      fetch(12'o200 + 12'(i), 1);
      if (i == 6) check("fill_busy7", 64'(busy), 64'(1));
      if (i == 7) check("fill_done8", 64'(done), 64'(1));
    end
    check("fill_count", 64'(count), 64'(8));
    check("fill_wrapped", 64'(wrapped), 64'(0));
    drain("fill", 12'o200, 8);

    // Circular mode: oldest two entries overwritten.
    do_arm(2'b01);
    for (int i = 0; i < 10; i++) fetch(12'o200 + 12'(i), 1);
    check("circ_busy", 64'(busy), 64'(1));
    do_stop();
    check("circ_done", 64'(done), 64'(1));
    check("circ_count", 64'(count), 64'(8));
    check("circ_wrapped", 64'(wrapped), 64'(1));
    drain("circ", 12'o202, 8);

    // Trigger mode: trigger at 0205, two post fetches.
    trig_pc = 12'o205;
    do_arm(2'b10);
    for (int i = 0; i < 11; i++) begin
      fetch(12'o200 + 12'(i), 1);
      if (i == 4) check("trig_pre", 64'(triggered), 64'(0));
      if (i == 6) check("trig_post_busy", 64'(busy), 64'(1));
      if (i == 7) check("trig_done", 64'(done), 64'(1));
    end
    check("trig_flag", 64'(triggered), 64'(1));
    check("trig_count", 64'(count), 64'(8));
    drain("trig", 12'o200, 8);

    // Halt ends capture without writing an entry.
    do_arm(2'b01);
    for (int i = 0; i < 3; i++) fetch(12'o300 + 12'(i), 1);
    cpu_state = 4'b1100;
    tick();
    cpu_state = 4'b0001;
    check("halt_flags", 64'({halted, done, busy}), 64'(3'b110));
    check("halt_count", 64'(count), 64'(3));
    fetch(12'o310, 1);
    fetch(12'o311, 1);
    check("halt_nocap", 64'(count), 64'(3));

    // Field packing and handshake stall.
    do_arm(2'b01);
    cpu_state = 4'b0000; cpu_pc = 12'o200; cpu_mb = 12'o7402;
    cpu_l = 1'b1; cpu_ac = 12'o1234; cpu_ion = 1'b1;
    tick();
    cpu_state = 4'b0001; cpu_l = 1'b0; cpu_ion = 1'b0;
    tick();
    fetch(12'o201, 1);
    fetch(12'o202, 1);
    do_stop();
    for (int i = 0; i < 5; i++) tick();
    check("data_fields", 64'(rd_data), 64'({12'o200, 12'o7402, 1'b1, 12'o1234, 1'b1}));
    check("stall_count", 64'(count), 64'(3));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("pop_next", 64'(rd_data[37:26]), 64'(12'o201));
    check("pop_count", 64'(count), 64'(2));
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    tick();
    reset_n = 1'b1;
    tick();

    // Timestamps: fetches four clocks apart.
    do_arm(2'b01);
    for (int i = 0; i < 4; i++) fetch(12'o400 + 12'(i), 3);
    do_stop();
    rd_ready = 1'b1;
    prev_ts = rd_ts;
`ifndef PDP8_TRACE_TIMESTAMP_EN
    check("ts_zero", 64'(rd_ts), 64'(0));
`endif
    tick();
    for (int i = 1; i < 4; i++) begin
`ifdef PDP8_TRACE_TIMESTAMP_EN
      check("ts_delta", 64'(rd_ts - prev_ts), 64'(4));
`else
      check("ts_zero", 64'(rd_ts), 64'(0));
`endif
      check("ts_pc", 64'(rd_data[37:26]), 64'(12'o400 + 12'(i)));
      prev_ts = rd_ts;
      tick();
    end
    rd_ready = 1'b0;
    check("ts_empty", 64'(rd_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
